mips_fetch_unit: RTL and testbench
==================================

// Module: mips_fetch_unit
// PURPOSE
// - Parametrised instruction-fetch stage for the MIPS core. Replaces the combinational PC/PC+4/branch-mux path.
// - Owns the fetch PC and issues requests to a variable-latency instruction memory over a valid/ready interface.
// - Buffers returned instructions, each with its PC, in a DEPTH-entry in-order FIFO.
// - Presents the FIFO head to decode over a valid/ready handshake.
// - On a redirect (branch/jump/jr), flushes the FIFO and discards stale in-flight responses.
// PARAMETERS
// XLEN        32    width of PC, address and instruction words
// DEPTH       4     instruction FIFO entries (power of 2, >=2); also the maximum number of outstanding requests
// RESET_PC    0     fetch PC after reset (word aligned)
// PORTS
// clk             in   1          clock; all state updates on posedge
// rst_n           in   1          asynchronous active-low reset
// imem_req_valid  out  1          fetch request valid
// imem_req_ready  in   1          memory accepts request this cycle
// imem_req_addr   out  XLEN       byte address of request (bits[1:0]=0)
// imem_rsp_valid  in   1          instruction returned this cycle (in request order, never backpressured)
// imem_rsp_data   in   XLEN       returned instruction word
// redirect_valid  in   1          one-cycle pulse: restart fetch at redirect_pc
// redirect_pc     in   XLEN       new fetch target
// halt            in   1          level: stop issuing new requests
// if_valid        out  1          FIFO head valid to decode
// if_ready        in   1          decode consumes head this cycle
// if_instr        out  XLEN       head instruction
// if_pc           out  XLEN       head PC
// if_pc4          out  XLEN       head PC+4, modulo 2^XLEN
// fetch_misalign  out  1          registered pulse: last redirect_pc had bits[1:0]!=0
// fifo_count      out  clog2(DEPTH+1)  current FIFO occupancy
// BEHAVIOUR
// - Reset values: fetch_pc=resp_pc=RESET_PC; FIFO empty; outstanding=0; drop_cnt=0.
//   Outputs: imem_req_valid=0, imem_req_addr=RESET_PC, if_valid=0, if_instr/if_pc=0, if_pc4=4, fetch_misalign=0, fifo_count=0.
// - Credits: credits = DEPTH - fifo_count - outstanding.
//   imem_req_valid = !halt && !redirect_valid && drop_cnt==0 && credits>0, so the FIFO never overflows.
// - imem_req_addr = fetch_pc.
//   On request handshake: fetch_pc += 4 (wraps mod 2^XLEN); outstanding += 1.
// - Response with drop_cnt==0:
//   - push {imem_rsp_data, resp_pc}; resp_pc += 4; outstanding -= 1.
//   - Latency: a response at cycle N is visible on if_valid at cycle N+1. No bypass, including when the FIFO is empty.
// - Response with drop_cnt>0: discarded; drop_cnt -= 1; outstanding -= 1.
// - Pop: if_valid && if_ready. Push and pop in the same cycle are both honoured; fifo_count is unchanged.
// - Redirect cycle (highest priority):
//   - FIFO cleared (fifo_count=0, if_valid=0 next cycle); no request issued.
//   - Any response arriving this cycle is discarded.
//   - drop_cnt <= outstanding (minus 1 if a response arrived this cycle); outstanding is unchanged except for that arrival.
//   - fetch_pc and resp_pc <= {redirect_pc[XLEN-1:2],2'b00}.
//   - fetch_misalign <= |redirect_pc[1:0] for exactly one cycle.
//   - A pop in the redirect cycle still completes for decode; the FIFO is cleared regardless.
// - Back-to-back redirects: the second redirect overrides the first; drop_cnt recomputed from current outstanding.
// - halt: blocks new requests only. Outstanding responses still land; the FIFO still drains to decode.
// - Reset asserted mid-operation: all state returns to reset values immediately (async); in-flight memory responses after
//   rst_n release are the memory's responsibility to squash (memory shares rst_n).
// - No FSM beyond the counters: states are implied by (drop_cnt>0 = DRAIN, halt = IDLE, else RUN).
// TESTING
// 1. Reset; imem always ready, 1-cycle latency, if_ready=1 -> addrs 0,4,8,... issued back-to-back; if_pc follows 0,4,8; if_pc4=if_pc+4.
// 2. if_ready=0, latency 1 -> exactly DEPTH(4) requests issued then imem_req_valid=0; fifo_count=4;
//    raising if_ready resumes issue the cycle after the first pop.
// 3. Latency 3, three requests outstanding, redirect_pc=0x100 -> three stale responses discarded; next if_pc=0x100, then 0x104.
// 4. redirect_pc=0x202 -> fetch_misalign=1 for one cycle; imem_req_addr=0x200.
// 5. redirect_pc=0xFFFFFFF8, run -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; if_pc4 of 0xFFFFFFFC = 0.
// 6. halt=1 with 2 outstanding -> no new requests; both instructions delivered; deasserting halt resumes at the next PC.
//    Then assert rst_n=0 with FIFO non-empty -> all outputs immediately at reset values.

Source files
------------

// File: rtl/mips_fetch_unit.sv
// Instruction-fetch stage for the MIPS core.
// Owns the fetch PC, issues word requests to a variable-latency instruction
// memory, buffers returned words (each tagged with its PC) in an in-order
// FIFO and hands the FIFO head to decode. A redirect flushes the FIFO and
// arms a drop counter that discards responses still in flight.
//
// Handshake semantics (all three interfaces): a transfer happens in a cycle
// where valid and ready are both high at the rising clock edge. The
// request side never withdraws on its own account. Its valid only depends on
// halt, redirect, drop state and credits. The response side has no ready: a
// response is always taken, either into the FIFO or into the drop counter.
//
// There is no explicit FSM. The operating mode follows from the counters:
// drop_cnt_q != 0 is DRAIN, halt is IDLE, anything else is RUN.
module mips_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       imem_req_valid,
  input  logic                       imem_req_ready,
  output logic [XLEN-1:0]            imem_req_addr,
  input  logic                       imem_rsp_valid,
  input  logic [XLEN-1:0]            imem_rsp_data,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  input  logic                       halt,
  output logic                       if_valid,
  input  logic                       if_ready,
  output logic [XLEN-1:0]            if_instr,
  output logic [XLEN-1:0]            if_pc,
  output logic [XLEN-1:0]            if_pc4,
  output logic                       fetch_misalign,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  // Architectural state
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic            misalign_q, misalign_d;

  // FIFO storage (data path only, no reset needed: head is gated by if_valid)
  logic [XLEN-1:0] instr_mem_q [DEPTH];
  logic [XLEN-1:0] pc_mem_q    [DEPTH];

  // Event strobes
  logic            req_fire;
  logic            push;
  logic            pop;
  logic [CW:0]     used;

  // Slots already committed: buffered words plus requests still in flight.
  // Issuing only while used < DEPTH guarantees every response has a slot.
  assign used = {1'b0, count_q} + {1'b0, outstanding_q};

  // Request side: gated by reset so the port is quiet while rst_n is low
  assign imem_req_valid = rst_n && !halt && !redirect_valid &&
                          (drop_cnt_q == '0) && (used < DEPTH_W);
  assign imem_req_addr  = fetch_pc_q;

  assign req_fire = imem_req_valid && imem_req_ready;
  assign push     = imem_rsp_valid && !redirect_valid && (drop_cnt_q == '0);
  assign pop      = if_valid && if_ready;

  // Decode side: head fields read as zero whenever the FIFO is empty
  assign if_valid       = (count_q != '0);
  assign if_instr       = if_valid ? instr_mem_q[rd_ptr_q] : '0;
  assign if_pc          = if_valid ? pc_mem_q[rd_ptr_q] : '0;
  assign if_pc4         = if_pc + XLEN'(4);
  assign fetch_misalign = misalign_q;
  assign fifo_count     = count_q;

  // Next-state computation; a redirect overrides every other update
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    drop_cnt_d    = drop_cnt_q;
    misalign_d    = 1'b0;
    // In-flight count tracks the memory regardless of redirects
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);

    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      resp_pc_d  = {redirect_pc[XLEN-1:2], 2'b00};
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      // Everything still in flight after this cycle is stale
      drop_cnt_d = outstanding_q - CW'(imem_rsp_valid);
      misalign_d = |redirect_pc[1:0];
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
      if (imem_rsp_valid && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end
      if (push) begin
        resp_pc_d = resp_pc_q + XLEN'(4);
        wr_ptr_d  = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Control and pointer registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      misalign_q    <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      misalign_q    <= misalign_d;
    end
  end

  // FIFO write port: store the returned word with the PC it was fetched from
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= imem_rsp_data;
      pc_mem_q[wr_ptr_q]    <= resp_pc_q;
    end
  end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit: a latency-programmable memory model,
// a decode-side pop recorder and hand-computed expectations per scenario.
module tb_mips_fetch_unit;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            halt;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_pc4;
  logic            fetch_misalign;
  logic [2:0]      fifo_count;

  mips_fetch_unit #(.XLEN(XLEN), .DEPTH(4), .RESET_PC('0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc4         (if_pc4),
    .fetch_misalign (fetch_misalign),
    .fifo_count     (fifo_count)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [XLEN-1:0] addr;
    int              due;
  } req_t;

  req_t            mem_q[$];
  int              mem_lat = 1;
  logic [XLEN-1:0] addr_q[$];
  logic [XLEN-1:0] got_pc[$];
  logic [XLEN-1:0] got_pc4[$];
  logic [XLEN-1:0] got_instr[$];

  function automatic logic [XLEN-1:0] mem_data(input logic [XLEN-1:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic check(input string tag, input logic [XLEN-1:0] obs,
                       input logic [XLEN-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  // ---------------- memory model ----------------
  // Response for a request accepted in cycle K is driven during cycle K+lat.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      if (!rst_n) begin
        mem_q.delete();
      end else if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_data(mem_q[0].addr);
        void'(mem_q.pop_front());
      end
      @(negedge clk);
      if (rst_n && imem_req_valid && imem_req_ready) begin
        mem_q.push_back('{addr: imem_req_addr, due: cyc + mem_lat});
        addr_q.push_back(imem_req_addr);
      end
    end
  end

  // ---------------- decode-side recorder ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && if_valid && if_ready) begin
        got_pc.push_back(if_pc);
        got_pc4.push_back(if_pc4);
        got_instr.push_back(if_instr);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    addr_q.delete();
    got_pc.delete();
    got_pc4.delete();
    got_instr.delete();
  endtask

  // Stop issue and let everything in flight land and drain to decode
  task automatic drain();
    halt     = 1'b1;
    if_ready = 1'b1;
    repeat (8) step();
    clear_logs();
  endtask

  // Pulse redirect for the current cycle
  task automatic do_redirect(input logic [XLEN-1:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
    redirect_pc    = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halt           = 1'b0;
    if_ready       = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_req_addr", imem_req_addr, 32'h0);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_if_pc4", if_pc4, 32'h4);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);

    // 1: back-to-back fetch from RESET_PC, latency 1, decode always ready
    step();
    rst_n   = 1'b1;
    mem_lat = 1;
    repeat (10) step();
    check("t1_num_req", 32'(addr_q.size()), 32'd10);
    check("t1_addr1", addr_q[1], 32'h4);
    check("t1_addr9", addr_q[9], 32'h24);
    check("t1_num_pop", 32'(got_pc.size()), 32'd8);
    check("t1_pc0", got_pc[0], 32'h0);
    check("t1_pc2", got_pc[2], 32'h8);
    check("t1_pc4_1", got_pc4[1], 32'h8);
    check("t1_instr1", got_instr[1], 32'h5A5A_A5A1);

    // 2: decode stalled, credits stop issue at DEPTH
    drain();
    do_redirect(32'h40);
    if_ready = 1'b0;
    halt     = 1'b0;
    repeat (8) step();
    @(negedge clk);
    check("t2_num_req", 32'(addr_q.size()), 32'd4);
    check("t2_last_addr", addr_q[3], 32'h4C);
    check("t2_fifo_full", 32'(fifo_count), 32'd4);
    check("t2_req_blocked", 32'(imem_req_valid), 32'd0);
    check("t2_head_pc", if_pc, 32'h40);
    check("t2_head_instr", if_instr, 32'h5A5A_A5E5);
    step();
    if_ready = 1'b1;
    @(negedge clk);
    check("t2_pop_cycle_req", 32'(imem_req_valid), 32'd0);
    step();
    @(negedge clk);
    check("t2_resume_req", 32'(imem_req_valid), 32'd1);
    check("t2_resume_addr", imem_req_addr, 32'h50);
    repeat (10) step();
    check("t2_pop0", got_pc[0], 32'h40);
    check("t2_pop3", got_pc[3], 32'h4C);
    check("t2_pop4", got_pc[4], 32'h50);

    // 3: redirect with three requests in flight at latency 3
    drain();
    mem_lat = 3;
    do_redirect(32'h80);
    halt = 1'b0;
    repeat (3) step();
    check("t3_in_flight", 32'(addr_q.size()), 32'd3);
    do_redirect(32'h100);
    @(negedge clk);
    check("t3_drop_blocks_req", 32'(imem_req_valid), 32'd0);
    check("t3_fetch_addr", imem_req_addr, 32'h100);
    check("t3_fifo_flushed", 32'(fifo_count), 32'd0);
    step();
    @(negedge clk);
    check("t3_stale_not_pushed", 32'(if_valid), 32'd0);
    repeat (12) step();
    check("t3_first_pc", got_pc[0], 32'h100);
    check("t3_first_instr", got_instr[0], 32'h5A5A_A4A5);
    check("t3_second_pc", got_pc[1], 32'h104);

    // 4: misaligned redirect target
    drain();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h202;
    @(negedge clk);
    check("t4_misalign_not_yet", 32'(fetch_misalign), 32'd0);
    step();
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    @(negedge clk);
    check("t4_misalign_pulse", 32'(fetch_misalign), 32'd1);
    check("t4_aligned_addr", imem_req_addr, 32'h200);
    step();
    @(negedge clk);
    check("t4_misalign_clear", 32'(fetch_misalign), 32'd0);

    // 5: PC wraps past the top of the address space
    drain();
    mem_lat = 1;
    do_redirect(32'hFFFF_FFF8);
    halt = 1'b0;
    repeat (6) step();
    check("t5_addr0", addr_q[0], 32'hFFFF_FFF8);
    check("t5_addr1", addr_q[1], 32'hFFFF_FFFC);
    check("t5_addr2", addr_q[2], 32'h0);
    check("t5_pc4_0", got_pc4[0], 32'hFFFF_FFFC);
    check("t5_pc1", got_pc[1], 32'hFFFF_FFFC);
    check("t5_pc4_wrap", got_pc4[1], 32'h0);
    check("t5_pc2", got_pc[2], 32'h0);

    // 6: halt with two in flight, then asynchronous reset with a full FIFO
    drain();
    mem_lat = 3;
    do_redirect(32'h300);
    halt = 1'b0;
    repeat (2) step();
    halt = 1'b1;
    @(negedge clk);
    check("t6_halt_blocks", 32'(imem_req_valid), 32'd0);
    repeat (6) step();
    check("t6_num_req", 32'(addr_q.size()), 32'd2);
    check("t6_num_pop", 32'(got_pc.size()), 32'd2);
    check("t6_pop0", got_pc[0], 32'h300);
    check("t6_pop1", got_pc[1], 32'h304);
    check("t6_instr1", got_instr[1], 32'h5A5A_A6A1);
    halt = 1'b0;
    @(negedge clk);
    check("t6_resume_req", 32'(imem_req_valid), 32'd1);
    check("t6_resume_addr", imem_req_addr, 32'h308);
    step();
    if_ready = 1'b0;
    repeat (6) step();
    check("t6_fifo_nonempty", 32'(fifo_count != 3'd0), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("t6_rst_req_addr", imem_req_addr, 32'h0);
    check("t6_rst_if_valid", 32'(if_valid), 32'd0);
    check("t6_rst_if_instr", if_instr, 32'h0);
    check("t6_rst_if_pc", if_pc, 32'h0);
    check("t6_rst_if_pc4", if_pc4, 32'h4);
    check("t6_rst_misalign", 32'(fetch_misalign), 32'd0);
    check("t6_rst_fifo_count", 32'(fifo_count), 32'd0);

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
